// File: rtl/ppu_pixel_fifo.sv
// Pixel FIFO between the PPU fetcher and the LCD: queues whole tile rows, drops fine-scroll pixels,
// overlays sprite rows onto the head entries and shades the head pixel through BGP/OBP0/OBP1.
module ppu_pixel_fifo #(
    parameter int TILE_W = 8,
    parameter int BPP    = 2,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [2:0]                    discard,
    input  logic                          bg_en,
    input  logic                          obj_en,
    input  logic [(1<<BPP)*BPP-1:0]       bgp,
    input  logic [(1<<BPP)*BPP-1:0]       obp0,
    input  logic [(1<<BPP)*BPP-1:0]       obp1,
    input  logic                          row_valid,
    output logic                          row_ready,
    input  logic [BPP*TILE_W-1:0]         row_planes,
    input  logic                          spr_valid,
    output logic                          spr_ready,
    input  logic [BPP*TILE_W-1:0]         spr_planes,
    input  logic                          spr_pal,
    input  logic                          spr_prio,
    output logic                          px_valid,
    input  logic                          px_ready,
    output logic [BPP-1:0]                px_out,
    output logic                          px_src,
    output logic [$clog2(DEPTH+1)-1:0]    level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int PAL_W = (1<<BPP)*BPP;
    localparam int ROW_W = BPP*TILE_W;
    localparam logic [LVL_W-1:0] ROW_ROOM = LVL_W'(DEPTH - TILE_W);
    localparam logic [LVL_W-1:0] ROW_LVL  = LVL_W'(TILE_W);

    logic [BPP-1:0]   bg_idx_q   [DEPTH];
    logic [BPP-1:0]   bg_idx_d   [DEPTH];
    logic [BPP-1:0]   obj_idx_q  [DEPTH];
    logic [BPP-1:0]   obj_idx_d  [DEPTH];
    logic             obj_pal_q  [DEPTH];
    logic             obj_pal_d  [DEPTH];
    logic             obj_prio_q [DEPTH];
    logic             obj_prio_d [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [2:0]       discard_cnt_q, discard_cnt_d;

    logic do_push, do_merge, do_pop, do_drop, advance;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(k);
        if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    // Pixel k takes one bit from each plane; the MSB of a plane is the leftmost pixel.
    function automatic logic [BPP-1:0] pix_idx(input logic [ROW_W-1:0] planes, input int k);
        logic [BPP-1:0] idx;
        for (int p = 0; p < BPP; p++) begin
            idx[p] = planes[p*TILE_W + (TILE_W-1) - k];
        end
        return idx;
    endfunction

    assign row_ready = rst_n && !flush && (level_q <= ROW_ROOM);
    assign spr_ready = rst_n && !flush && (level_q >= ROW_LVL);
    assign do_push   = row_valid && row_ready;
    assign do_merge  = spr_valid && spr_ready;
    assign px_valid  = rst_n && !flush && (level_q != '0) && (discard_cnt_q == '0) && !do_merge;
    assign do_pop    = px_valid && px_ready;
    assign do_drop   = rst_n && !flush && (discard_cnt_q != '0) && (level_q != '0);
    assign advance   = do_pop || do_drop;
    assign level     = level_q;

    // Merge and push never touch the same slots: merge needs level >= TILE_W, push needs room for TILE_W.
    always_comb begin
        logic [PTR_W-1:0] slot;
        logic [BPP-1:0]   sidx;
        bg_idx_d   = bg_idx_q;
        obj_idx_d  = obj_idx_q;
        obj_pal_d  = obj_pal_q;
        obj_prio_d = obj_prio_q;
        slot       = '0;
        sidx       = '0;
        for (int k = 0; k < TILE_W; k++) begin
            if (do_merge) begin
                slot = ptr_add(head_q, k);
                sidx = pix_idx(spr_planes, k);
                if (obj_idx_q[slot] == '0 && sidx != '0) begin
                    obj_idx_d[slot]  = sidx;
                    obj_pal_d[slot]  = spr_pal;
                    obj_prio_d[slot] = spr_prio;
                end
            end
            if (do_push) begin
                slot = ptr_add(tail_q, k);
                bg_idx_d[slot]   = pix_idx(row_planes, k);
                obj_idx_d[slot]  = '0;
                obj_pal_d[slot]  = 1'b0;
                obj_prio_d[slot] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        bg_idx_q   <= bg_idx_d;
        obj_idx_q  <= obj_idx_d;
        obj_pal_q  <= obj_pal_d;
        obj_prio_q <= obj_prio_d;
    end

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        level_d       = level_q;
        discard_cnt_d = discard_cnt_q;
        if (flush) begin
            head_d        = '0;
            tail_d        = '0;
            level_d       = '0;
            discard_cnt_d = discard;
        end else begin
            if (advance) head_d = ptr_add(head_q, 1);
            if (do_push) tail_d = ptr_add(tail_q, TILE_W);
            if (do_drop) discard_cnt_d = discard_cnt_q - 3'd1;
            level_d = level_q + (do_push ? ROW_LVL : '0) - (advance ? LVL_W'(1) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            level_q       <= '0;
            discard_cnt_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            level_q       <= level_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    logic [BPP-1:0]   head_bg, head_obj, bg_eff;
    logic             head_pal, head_prio, obj_wins;
    logic [PAL_W-1:0] obj_palette;

    assign head_bg     = bg_idx_q[head_q];
    assign head_obj    = obj_idx_q[head_q];
    assign head_pal    = obj_pal_q[head_q];
    assign head_prio   = obj_prio_q[head_q];
    assign bg_eff      = bg_en ? head_bg : '0;
    assign obj_wins    = obj_en && (head_obj != '0) && (!head_prio || bg_eff == '0);
    assign obj_palette = head_pal ? obp1 : obp0;

    always_comb begin
        px_out = '0;
        px_src = 1'b0;
        if (rst_n) begin
            if (obj_wins) begin
                px_out = obj_palette[head_obj*BPP +: BPP];
                px_src = 1'b1;
            end else begin
                px_out = bgp[bg_eff*BPP +: BPP];
            end
        end
    end

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Self-checking bench for ppu_pixel_fifo: a queue-based model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_ppu_pixel_fifo;

    localparam int TILE_W = 8;
    localparam int BPP    = 2;
    localparam int DEPTH  = 16;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  discard;
    logic        bg_en, obj_en;
    logic [7:0]  bgp, obp0, obp1;
    logic        row_valid, row_ready;
    logic [15:0] row_planes;
    logic        spr_valid, spr_ready;
    logic [15:0] spr_planes;
    logic        spr_pal, spr_prio;
    logic        px_valid, px_ready;
    logic [1:0]  px_out;
    logic        px_src;
    logic [4:0]  level;

    ppu_pixel_fifo #(.TILE_W(TILE_W), .BPP(BPP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .discard(discard),
        .bg_en(bg_en), .obj_en(obj_en), .bgp(bgp), .obp0(obp0), .obp1(obp1),
        .row_valid(row_valid), .row_ready(row_ready), .row_planes(row_planes),
        .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_planes(spr_planes),
        .spr_pal(spr_pal), .spr_prio(spr_prio),
        .px_valid(px_valid), .px_ready(px_ready), .px_out(px_out), .px_src(px_src),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] bg;
        logic [1:0] obj;
        logic       pal;
        logic       prio;
    } ent_t;

    ent_t mq[$];
    int   mdisc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   check_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_pix(input logic [15:0] planes, input int k);
        return {planes[8 + 7 - k], planes[7 - k]};
    endfunction

    function automatic logic [1:0] shade(input logic [7:0] pal, input logic [1:0] idx);
        return 2'((pal >> (2 * idx)) & 8'h3);
    endfunction

    function automatic bit m_row_ready();
        return (rst_n === 1'b1) && (flush === 1'b0) && (mq.size() <= DEPTH - TILE_W);
    endfunction

    function automatic bit m_spr_ready();
        return (rst_n === 1'b1) && (flush === 1'b0) && (mq.size() >= TILE_W);
    endfunction

    function automatic bit m_px_valid();
        return (rst_n === 1'b1) && (flush === 1'b0) && (mq.size() > 0) && (mdisc == 0)
               && !(spr_valid && m_spr_ready());
    endfunction

    function automatic void m_mix(output logic [1:0] o, output logic s);
        ent_t e;
        int   b;
        e = mq[0];
        b = bg_en ? int'(e.bg) : 0;
        if (obj_en && e.obj != 0 && (!e.prio || b == 0)) begin
            o = shade(e.pal ? obp1 : obp0, e.obj);
            s = 1'b1;
        end else begin
            o = shade(bgp, 2'(b));
            s = 1'b0;
        end
    endfunction

    // Model advance: all decisions use the state and inputs seen just before the edge.
    always @(posedge clk) begin
        bit         rr, sr, pv;
        ent_t       e;
        logic [1:0] sp;
        rr = m_row_ready();
        sr = m_spr_ready();
        pv = m_px_valid();
        if (rst_n !== 1'b1) begin
            mq.delete();
            mdisc = 0;
        end else if (flush) begin
            mq.delete();
            mdisc = int'(discard);
        end else begin
            if (spr_valid && sr) begin
                for (int k = 0; k < TILE_W; k++) begin
                    sp = m_pix(spr_planes, k);
                    e  = mq[k];
                    if (e.obj == 0 && sp != 0) begin
                        e.obj  = sp;
                        e.pal  = spr_pal;
                        e.prio = spr_prio;
                        mq[k]  = e;
                    end
                end
            end
            if (mdisc > 0 && mq.size() > 0) begin
                void'(mq.pop_front());
                mdisc--;
            end else if (pv && px_ready) begin
                void'(mq.pop_front());
            end
            if (row_valid && rr) begin
                for (int k = 0; k < TILE_W; k++) begin
                    e.bg = m_pix(row_planes, k);
                    e.obj = 2'd0;
                    e.pal = 1'b0;
                    e.prio = 1'b0;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] eo;
        logic       es;
        if (check_en) begin
            chk("row_ready", row_ready, m_row_ready());
            chk("spr_ready", spr_ready, m_spr_ready());
            chk("px_valid", px_valid, m_px_valid());
            chk("level", level, mq.size());
            if (rst_n !== 1'b1) begin
                chk("px_out_rst", px_out, 0);
                chk("px_src_rst", px_src, 0);
            end else if (m_px_valid()) begin
                m_mix(eo, es);
                chk("px_out", px_out, eo);
                chk("px_src", px_src, es);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [1:0] eo, input logic es);
        @(negedge clk);
        chk({name, "_valid"}, px_valid, ev);
        if (ev) begin
            chk({name, "_out"}, px_out, eo);
            chk({name, "_src"}, px_src, es);
        end
        tick();
    endtask

    task automatic runT4(input logic prio, input logic objen, input logic [15:0] eo, input logic [7:0] es);
        px_ready   = 1'b0;
        obj_en     = objen;
        row_valid  = 1'b1;
        row_planes = {8'h00, 8'hFF};
        tick();
        row_valid  = 1'b0;
        spr_valid  = 1'b1;
        spr_planes = {8'h0F, 8'h0F};
        spr_pal    = 1'b0;
        spr_prio   = prio;
        @(negedge clk);
        chk("t4_spr_ready", spr_ready, 1);
        chk("t4_merge_blocks", px_valid, 0);
        tick();
        spr_valid = 1'b0;
        px_ready  = 1'b1;
        for (int i = 0; i < 8; i++) checkOutput("t4_px", 1'b1, eo[2*i +: 2], es[i]);
        px_ready = 1'b0;
        obj_en   = 1'b1;
    endtask

    task automatic applyStimulus();
        rst_n      = ($urandom_range(0, 399) != 0);
        flush      = ($urandom_range(0, 47) == 0);
        discard    = 3'($urandom);
        bg_en      = ($urandom_range(0, 7) != 0);
        obj_en     = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) begin
            bgp  = 8'($urandom);
            obp0 = 8'($urandom);
            obp1 = 8'($urandom);
        end
        row_valid  = ($urandom_range(0, 1) == 0);
        row_planes = 16'($urandom);
        spr_valid  = ($urandom_range(0, 3) == 0);
        spr_planes = 16'($urandom);
        spr_pal    = 1'($urandom);
        spr_prio   = 1'($urandom);
        px_ready   = ($urandom_range(0, 9) < 7);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] rowB, rowC;
        int          pops;
        bit          got;

        rst_n = 1'b0; flush = 1'b0; discard = 3'd0; bg_en = 1'b1; obj_en = 1'b1;
        bgp = 8'hE4; obp0 = 8'hE4; obp1 = 8'h1B;
        row_valid = 1'b0; row_planes = '0; spr_valid = 1'b0; spr_planes = '0;
        spr_pal = 1'b0; spr_prio = 1'b0; px_ready = 1'b0;

        tick();
        check_en = 1;
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_out", px_out, 0);
        chk("rst_row_ready", row_ready, 0);
        tick();
        rst_n = 1'b1;

        // T1: plain row, eight shaded pixels starting the cycle after acceptance.
        row_valid  = 1'b1;
        row_planes = {8'h7E, 8'h3C};
        px_ready   = 1'b1;
        @(negedge clk);
        chk("t1_row_ready", row_ready, 1);
        tick();
        row_valid = 1'b0;
        for (int i = 0; i < 8; i++) checkOutput("t1_px", 1'b1, 2'(16'h2FF8 >> (2*i)), 1'b0);
        checkOutput("t1_empty", 1'b0, 2'd0, 1'b0);

        // T2: flush with a fine-scroll discard of 3.
        flush = 1'b1; discard = 3'd3;
        tick();
        flush = 1'b0; discard = 3'd0;
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        for (int i = 0; i < 3; i++) checkOutput("t2_discard", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) checkOutput("t2_px", 1'b1, 2'(10'h0BF >> (2*i)), 1'b0);
        @(negedge clk);
        chk("t2_level", level, 0);
        tick();

        // T3: back-pressure, third row waits for room.
        px_ready   = 1'b0;
        row_valid  = 1'b1;
        row_planes = 16'($urandom);
        tick();
        row_planes = 16'($urandom);
        tick();
        row_planes = 16'($urandom);
        @(negedge clk);
        chk("t3_full_ready", row_ready, 0);
        chk("t3_full_level", level, 16);
        tick();
        px_ready = 1'b1;
        pops = 0;
        got  = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (row_ready === 1'b1) begin
                got = 1;
                chk("t3_pops", pops, 8);
                chk("t3_level", level, 8);
            end else if (px_valid === 1'b1) begin
                pops++;
            end
            tick();
        end
        if (!got) chk("t3_timeout", 0, 1);
        row_valid = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        chk("t3_drained", level, 0);
        tick();

        // T4: sprite overlay, priority and obj_en.
        runT4(1'b0, 1'b1, 16'hFF55, 8'hF0);
        runT4(1'b1, 1'b1, 16'h5555, 8'h00);
        runT4(1'b0, 1'b0, 16'h5555, 8'h00);

        // T5: push and pop together at level 1.
        row_valid  = 1'b1;
        row_planes = 16'($urandom);
        tick();
        row_valid = 1'b0;
        px_ready  = 1'b1;
        repeat (7) tick();
        rowB       = 16'($urandom);
        row_valid  = 1'b1;
        row_planes = rowB;
        @(negedge clk);
        chk("t5_level1", level, 1);
        chk("t5_valid", px_valid, 1);
        chk("t5_ready", row_ready, 1);
        tick();
        row_valid = 1'b0;
        px_ready  = 1'b0;
        @(negedge clk);
        chk("t5_level8", level, 8);
        tick();
        px_ready = 1'b1;
        for (int i = 0; i < 8; i++) checkOutput("t5_px", 1'b1, m_pix(rowB, i), 1'b0);
        px_ready = 1'b0;

        // T6: reset in the middle of a stream.
        row_valid  = 1'b1;
        row_planes = 16'($urandom);
        tick();
        row_planes = 16'($urandom);
        tick();
        row_valid = 1'b0;
        px_ready  = 1'b1;
        repeat (4) tick();
        px_ready = 1'b0;
        @(negedge clk);
        chk("t6_level12", level, 12);
        tick();
        rst_n      = 1'b0;
        row_valid  = 1'b1;
        rowC       = 16'($urandom);
        row_planes = rowC;
        @(negedge clk);
        chk("t6_rst_valid", px_valid, 0);
        chk("t6_rst_out", px_out, 0);
        chk("t6_rst_row_ready", row_ready, 0);
        chk("t6_rst_spr_ready", spr_ready, 0);
        tick();
        rst_n     = 1'b1;
        row_valid = 1'b0;
        @(negedge clk);
        chk("t6_level0", level, 0);
        chk("t6_valid0", px_valid, 0);
        chk("t6_row_ready", row_ready, 1);
        tick();
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        px_ready  = 1'b1;
        for (int i = 0; i < 8; i++) checkOutput("t6_px", 1'b1, m_pix(rowC, i), 1'b0);
        checkOutput("t6_empty", 1'b0, 2'd0, 1'b0);

        repeat (4000) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
